// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 pins into the Clk domain and reports psClk
// falling edges as a single-cycle pulse.
// Optional macro PS2_RX_GLITCH_FILTER_EN: adds a FILT_LEN-sample stability
// filter on the synchronized clock level before edge detection.
module ps2_sync_edge #(
  parameter int FILT_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps_clk,
  input  logic i_ps_dat,
  output logic o_dat,
  output logic o_fall
);

  if (FILT_LEN < 2 || FILT_LEN > 32) begin : g_bad_filt_len
    $error("FILT_LEN must be within 2..32");
  end

  logic r_clk_m, r_clk_s;
  logic r_dat_m, r_dat_s;
  logic r_prev;
  logic w_lvl;

  // Two-flop synchronizers for both pins; idle bus level is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_m <= 1'b1;
      r_clk_s <= 1'b1;
      r_dat_m <= 1'b1;
      r_dat_s <= 1'b1;
    end else begin
      r_clk_m <= i_ps_clk;
      r_clk_s <= r_clk_m;
      r_dat_m <= i_ps_dat;
      r_dat_s <= r_dat_m;
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN);

  logic           r_filt;
  logic [FCW-1:0] r_fcnt;

  // Filtered level follows the input only after FILT_LEN consecutive
  // samples at the new level; any return to the old level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FCW'(FILT_LEN - 1)) begin
      r_filt <= r_clk_s;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FCW'(1);
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_clk_s;
`endif

  // Previous clock level, used to spot the high-to-low transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b1;
    else          r_prev <= w_lvl;
  end

  assign o_fall = r_prev & ~w_lvl;
  assign o_dat  = r_dat_s;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Emits one registered strobe per frame (good byte, parity
// error or framing/timeout error) and discards bad frames.
// Optional macro PS2_RX_GLITCH_FILTER_EN enables the psClk glitch filter
// inside ps2_sync_edge.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000,
  parameter int FILT_LEN    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err_parity,
  output logic       rx_err_frame,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  if (TIMEOUT_CYC < 16) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 16");
  end

  logic w_fall, w_dat;

  ps2_sync_edge #(.FILT_LEN(FILT_LEN)) u_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_ps_clk(psClk),
    .i_ps_dat(psData),
    .o_dat   (w_dat),
    .o_fall  (w_fall)
  );

  ps2_rx_state_t r_state, w_state_nxt;
  logic [7:0]    r_shift, r_data;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_valid, r_perr, r_ferr, r_busy;
  logic          w_valid_nxt, w_perr_nxt, w_ferr_nxt;
  logic          w_timeout;

  // A stalled frame expires only if no edge arrives in the expiring cycle.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and frame verdict; stop=0 outranks a parity failure.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE:   if (w_fall && !w_dat) w_state_nxt = DATA;
      DATA:   if (w_fall && r_bitcnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
      PARITY: if (w_fall) w_state_nxt = STOP;
      STOP: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          if (!w_dat)                          w_ferr_nxt  = 1'b1;
          else if (odd_parity_ok(r_shift, r_par)) w_valid_nxt = 1'b1;
          else                                 w_perr_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_ferr_nxt  = 1'b1;
    end
  end

  // Shift register, bit counter, parity latch and output byte.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
    end else begin
      if (r_state == IDLE && w_fall && !w_dat) begin
        r_bitcnt <= '0;
      end else if (r_state == DATA && w_fall) begin
        r_shift  <= {w_dat, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (r_state == PARITY && w_fall) r_par <= w_dat;
      if (w_valid_nxt) r_data <= r_shift;
    end
  end

  // Inter-edge timeout counter: idle or any edge clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                      r_tcnt <= '0;
    else if (r_state == IDLE || w_fall || w_timeout) r_tcnt <= '0;
    else                                             r_tcnt <= r_tcnt + TW'(1);
  end

  // Registered single-cycle strobes and busy flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_err_parity = r_perr;
  assign rx_err_frame  = r_ferr;
  assign busy          = r_busy;

endmodule
